// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants for the iterative RV32M multiply/divide
//               sequencer: func3 encodings, FSM state encodings, defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int c_xlen_def  = 32;
    localparam int c_cnt_w_def = 6;

    // M-extension func3 encodings
    localparam logic [2:0] c_f3_mul    = 3'b000;
    localparam logic [2:0] c_f3_mulh   = 3'b001;
    localparam logic [2:0] c_f3_mulhsu = 3'b010;
    localparam logic [2:0] c_f3_mulhu  = 3'b011;
    localparam logic [2:0] c_f3_div    = 3'b100;
    localparam logic [2:0] c_f3_divu   = 3'b101;
    localparam logic [2:0] c_f3_rem    = 3'b110;
    localparam logic [2:0] c_f3_remu   = 3'b111;

    // Sequencer state encodings
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_calc  = 2'd1;
    localparam state_t c_st_fixup = 2'd2;
    localparam state_t c_st_done  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_datapath
// Description : Operand magnitude/sign capture, radix-2 shift-add multiply,
//               restoring divide, sign fixup, fast-path results and the
//               result register. Sequenced by load/step/fixup/fast strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = c_xlen_def
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            fixup,
    input  logic            fast,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            fast_hit,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    // {r_hi, r_lo} is the product register for multiply and {rem, quo} for divide;
    // r_opd holds the multiplicand or the divisor magnitude.
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opd;
    logic [XLEN-1:0] r_result;
    logic [2:0]      r_func3;
    logic            r_neg_q;
    logic            r_neg_r;

    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_fast_val;
    logic [XLEN-1:0] w_addend;
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_fix_val;

    // Which operand positions are interpreted as two's complement
    assign w_a_signed = (func3 == c_f3_mulh) | (func3 == c_f3_mulhsu) |
                        (func3 == c_f3_div)  | (func3 == c_f3_rem);
    assign w_b_signed = (func3 == c_f3_mulh) | (func3 == c_f3_div) | (func3 == c_f3_rem);
    assign w_sa       = w_a_signed & rs1[XLEN-1];
    assign w_sb       = w_b_signed & rs2[XLEN-1];
    assign w_abs_a    = w_sa ? -rs1 : rs1;
    assign w_abs_b    = w_sb ? -rs2 : rs2;

    // Cases resolved without iterating
    assign w_div0   = func3[2] & (rs2 == '0);
    assign w_ovf    = ((func3 == c_f3_div) | (func3 == c_f3_rem)) &
                      (rs1 == c_int_min) & (rs2 == '1);
    assign fast_hit = w_div0 | w_ovf;

    // Fast-path result: func3[1] separates remainder from quotient forms
    always_comb begin
        w_fast_val = '1;
        if (w_div0) begin
            w_fast_val = func3[1] ? rs1 : '1;
        end else begin
            w_fast_val = func3[1] ? '0 : c_int_min;
        end
    end

    // Multiply step: add multiplicand when the current multiplier bit is set
    assign w_addend  = r_lo[0] ? r_opd : '0;
    assign w_mul_sum = {1'b0, r_hi} + {1'b0, w_addend};

    // Divide step: the bit shifted out of rem forces "greater or equal";
    // otherwise the borrow of the XLEN+1 bit subtract is the compare.
    assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
    assign w_diff   = {1'b0, w_rem_sh[XLEN-1:0]} - {1'b0, r_opd};
    assign w_ge     = w_rem_sh[XLEN] | ~w_diff[XLEN];

    // Sign fixup on the finished magnitudes
    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_lo : r_lo;
    assign w_rem_fix  = r_neg_r ? -r_hi : r_hi;

    // Output word selection by the latched opcode
    always_comb begin
        w_fix_val = w_rem_fix;
        case (r_func3)
            c_f3_mul:                           w_fix_val = w_prod_fix[XLEN-1:0];
            c_f3_mulh, c_f3_mulhsu, c_f3_mulhu: w_fix_val = w_prod_fix[2*XLEN-1:XLEN];
            c_f3_div, c_f3_divu:                w_fix_val = w_quo_fix;
            default:                            w_fix_val = w_rem_fix;
        endcase
    end

    // Operand capture on accept, then one multiply/divide iteration per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_opd   <= '0;
            r_func3 <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (load) begin
            r_func3 <= func3;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_hi    <= '0;
            if (func3[2]) begin
                r_lo  <= w_abs_a;
                r_opd <= w_abs_b;
            end else begin
                r_lo  <= w_abs_b;
                r_opd <= w_abs_a;
            end
        end else if (step) begin
            if (r_func3[2]) begin
                if (w_ge) begin
                    r_hi <= w_diff[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b1};
                end else begin
                    r_hi <= w_rem_sh[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_mul_sum[XLEN:1];
                r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
        end
    end

    // Result register: written only by the fast path or by fixup
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else if (fast) begin
            r_result <= w_fast_val;
        end else if (fixup) begin
            r_result <= w_fix_val;
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative RV32M multiply/divide sequencer for EX. Stalls the
//               pipeline for XLEN iterations plus fixup and returns the result
//               with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = c_xlen_def,
    parameter int CNT_W = c_cnt_w_def
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_fast_hit;
    logic             w_load;
    logic             w_fast;
    logic             w_step;
    logic             w_fixup;
    logic             w_stall;

    assign w_accept = start & ~flush;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Iteration counter: loaded on accept, counts down once per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= c_cnt_last;
        end else if (w_step && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_cnt_one;
        end
    end

    // Next-state and datapath strobes; flush aborts CALC/FIXUP but never DONE
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_fast      = 1'b0;
        w_step      = 1'b0;
        w_fixup     = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_stall = 1'b1;
                    if (w_fast_hit) begin
                        w_fast      = 1'b1;
                        w_state_nxt = c_st_done;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = c_st_calc;
                    end
                end
            end
            c_st_calc: begin
                w_stall = 1'b1;
                if (flush) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = c_st_fixup;
                    end
                end
            end
            c_st_fixup: begin
                w_stall = 1'b1;
                if (flush) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_fixup     = 1'b1;
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // start is ignored while reset is held, so stall is masked by it too
    assign stall = w_stall & ~rst;
    assign done  = (r_state == c_st_done);

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .step     (w_step),
        .fixup    (w_fixup),
        .fast     (w_fast),
        .func3    (func3),
        .rs1      (rs1),
        .rs2      (rs2),
        .fast_hit (w_fast_hit),
        .result   (result)
    );

endmodule
`default_nettype wire
